// File: rtl/mrr_loopback_queue_rr_pkg.sv
// Shared defaults and FSM state types for the loopback message queue.
package mrr_loopback_queue_rr_pkg;

   localparam int unsigned NUM_CHAINS_DEF  = 4;
   localparam int unsigned CHIP_ID_LEN_DEF = 8;
   localparam int unsigned MSG_LEN_DEF     = 32;
   localparam int unsigned DEPTH_LOG2_DEF  = 4;
   localparam int unsigned SEQ_LEN_DEF     = 16;

   typedef enum logic {
      PIdle,
      PWait
   } push_state_e;

   typedef enum logic [1:0] {
      QIdle,
      QSearch,
      QResp
   } pop_state_e;

endpackage

// File: rtl/mrr_loopback_queue_rr_if.sv
// Push/pop handshake bundle between a node and its loopback queue.
interface mrr_loopback_queue_rr_if
   import mrr_loopback_queue_rr_pkg::*;
#(
   parameter int unsigned NUM_CHAINS  = NUM_CHAINS_DEF,
   parameter int unsigned CHIP_ID_LEN = CHIP_ID_LEN_DEF,
   parameter int unsigned MSG_LEN     = MSG_LEN_DEF,
   parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEF
);

   logic [NUM_CHAINS*CHIP_ID_LEN-1:0] pop_chip_id;
   logic [NUM_CHAINS-1:0]             pop_request;
   logic [NUM_CHAINS-1:0]             pop_ack;
   logic                              pop_hit;
   logic [MSG_LEN-1:0]                pop_message;
   logic [CHIP_ID_LEN-1:0]            push_chip_id;
   logic                              push_request;
   logic [MSG_LEN-1:0]                push_message;
   logic                              push_ack;
   logic                              full;
   logic [DEPTH_LOG2:0]               occupancy;

   modport master (
      output pop_chip_id, pop_request, push_chip_id, push_request, push_message,
      input  pop_ack, pop_hit, pop_message, push_ack, full, occupancy
   );

   modport slave (
      input  pop_chip_id, pop_request, push_chip_id, push_request, push_message,
      output pop_ack, pop_hit, pop_message, push_ack, full, occupancy
   );

endinterface

// File: rtl/mrr_loopback_entry_store.sv
// Entry array with lowest-free-slot write, single invalidate and single comb read port.
module mrr_loopback_entry_store #(
   parameter int unsigned CHIP_ID_LEN = 8,
   parameter int unsigned MSG_LEN     = 32,
   parameter int unsigned DEPTH_LOG2  = 4,
   parameter int unsigned SEQ_LEN     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [SEQ_LEN-1:0]     wr_seq,
   input  logic [CHIP_ID_LEN-1:0] wr_chip_id,
   input  logic [MSG_LEN-1:0]     wr_msg,
   input  logic                   inv_en,
   input  logic [DEPTH_LOG2-1:0]  inv_idx,
   input  logic [DEPTH_LOG2-1:0]  rd_idx,
   output logic                   rd_valid,
   output logic [SEQ_LEN-1:0]     rd_seq,
   output logic [CHIP_ID_LEN-1:0] rd_chip_id,
   output logic [MSG_LEN-1:0]     rd_msg,
   output logic                   full,
   output logic [DEPTH_LOG2:0]    occupancy
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

   typedef logic [DEPTH_LOG2-1:0] idx_t;
   typedef logic [DEPTH_LOG2:0]   occ_t;

   logic [DEPTH-1:0]       valid_q;
   logic [SEQ_LEN-1:0]     seq_q  [DEPTH];
   logic [CHIP_ID_LEN-1:0] chip_q [DEPTH];
   logic [MSG_LEN-1:0]     msg_q  [DEPTH];
   idx_t                   free_idx;
   logic                   do_wr;

   assign do_wr = wr_en && !full;

   // Lowest-index invalid entry is the push target.
   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) free_idx = idx_t'(i);
      end
   end

   // Population count of the valid vector.
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy = occupancy + occ_t'(valid_q[i]);
      end
   end

   assign full = &valid_q;

   // Valid bits: write and invalidate never hit the same slot (write only targets invalid ones).
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         if (do_wr) valid_q[free_idx] <= 1'b1;
         if (inv_en) valid_q[inv_idx] <= 1'b0;
      end
   end

   // Payload needs no reset; it is only observed through a set valid bit.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         seq_q[free_idx]  <= wr_seq;
         chip_q[free_idx] <= wr_chip_id;
         msg_q[free_idx]  <= wr_msg;
      end
   end

   assign rd_valid   = valid_q[rd_idx];
   assign rd_seq     = seq_q[rd_idx];
   assign rd_chip_id = chip_q[rd_idx];
   assign rd_msg     = msg_q[rd_idx];

endmodule

// File: rtl/mrr_loopback_queue_rr.sv
// Per-node loopback queue: 4-phase push, round-robin pop returning oldest entry per chip ID.
module mrr_loopback_queue_rr
   import mrr_loopback_queue_rr_pkg::*;
#(
   parameter int unsigned NUM_CHAINS  = NUM_CHAINS_DEF,
   parameter int unsigned CHIP_ID_LEN = CHIP_ID_LEN_DEF,
   parameter int unsigned MSG_LEN     = MSG_LEN_DEF,
   parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEF,
   parameter int unsigned SEQ_LEN     = SEQ_LEN_DEF
) (
   input logic                    clk,
   input logic                    rst,
   mrr_loopback_queue_rr_if.slave bus
);

   localparam int unsigned DEPTH   = 2 ** DEPTH_LOG2;
   localparam int unsigned CHAIN_W = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;

   typedef logic [DEPTH_LOG2-1:0] idx_t;
   typedef logic [CHAIN_W-1:0]    chain_t;

   push_state_e            p_state_q, p_state_d;
   pop_state_e             q_state_q, q_state_d;
   logic [SEQ_LEN-1:0]     seq_ctr_q;
   logic                   wr_en, inv_en, full;
   logic [DEPTH_LOG2:0]    occupancy;
   logic                   rd_valid;
   logic [SEQ_LEN-1:0]     rd_seq;
   logic [CHIP_ID_LEN-1:0] rd_chip_id;
   logic [MSG_LEN-1:0]     rd_msg;

   chain_t                 granted_q, granted_d, rr_q, rr_d, grant_idx, cand_chain;
   logic                   grant_valid;
   logic [CHIP_ID_LEN-1:0] req_id [NUM_CHAINS];
   logic [CHIP_ID_LEN-1:0] chip_q, chip_d;
   idx_t                   search_idx_q, search_idx_d, best_idx_q, best_idx_d;
   logic                   best_found_q, best_found_d, take;
   logic [SEQ_LEN-1:0]     best_seq_q, best_seq_d, age_new, age_best;
   logic [MSG_LEN-1:0]     best_msg_q, best_msg_d, pop_msg_q, pop_msg_d;
   logic [NUM_CHAINS-1:0]  pop_ack_q, pop_ack_d;
   logic                   pop_hit_q, pop_hit_d;

   mrr_loopback_entry_store #(
      .CHIP_ID_LEN(CHIP_ID_LEN),
      .MSG_LEN    (MSG_LEN),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .SEQ_LEN    (SEQ_LEN)
   ) u_store (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_seq    (seq_ctr_q),
      .wr_chip_id(bus.push_chip_id),
      .wr_msg    (bus.push_message),
      .inv_en    (inv_en),
      .inv_idx   (best_idx_q),
      .rd_idx    (search_idx_q),
      .rd_valid  (rd_valid),
      .rd_seq    (rd_seq),
      .rd_chip_id(rd_chip_id),
      .rd_msg    (rd_msg),
      .full      (full),
      .occupancy (occupancy)
   );

   // Push FSM: write on request acceptance, then hold ack until the request drops.
   always_comb begin
      p_state_d    = p_state_q;
      wr_en        = 1'b0;
      bus.push_ack = 1'b0;
      unique case (p_state_q)
         PIdle: begin
            if (bus.push_request && !full) begin
               wr_en     = 1'b1;
               p_state_d = PWait;
            end
         end
         PWait: begin
            bus.push_ack = 1'b1;
            if (!bus.push_request) p_state_d = PIdle;
         end
         default: p_state_d = PIdle;
      endcase
   end

   // Push state and free-running sequence counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_state_q <= PIdle;
         seq_ctr_q <= '0;
      end else begin
         p_state_q <= p_state_d;
         if (wr_en) seq_ctr_q <= seq_ctr_q + 1'b1;
      end
   end

   // Unpack per-chain chip IDs.
   always_comb begin
      for (int i = 0; i < NUM_CHAINS; i++) begin
         req_id[i] = bus.pop_chip_id[i*CHIP_ID_LEN +: CHIP_ID_LEN];
      end
   end

   // Round-robin: scan downwards so the first requester after rr_q wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand_chain  = '0;
      for (int k = NUM_CHAINS; k >= 1; k--) begin
         cand_chain = chain_t'((32'(rr_q) + 32'(k)) % NUM_CHAINS);
         if (bus.pop_request[cand_chain]) begin
            grant_valid = 1'b1;
            grant_idx   = cand_chain;
         end
      end
   end

   // Ages are both taken against the live counter, so they stay comparable across wrap.
   always_comb begin
      age_new  = seq_ctr_q - rd_seq;
      age_best = seq_ctr_q - best_seq_q;
      take     = rd_valid && (rd_chip_id == chip_q) && (!best_found_q || (age_new > age_best));
   end

   // Pop FSM: grant, linear scan of all entries, one-cycle response.
   always_comb begin
      q_state_d    = q_state_q;
      granted_d    = granted_q;
      chip_d       = chip_q;
      search_idx_d = search_idx_q;
      best_found_d = best_found_q;
      best_idx_d   = best_idx_q;
      best_seq_d   = best_seq_q;
      best_msg_d   = best_msg_q;
      rr_d         = rr_q;
      pop_ack_d    = '0;
      pop_hit_d    = pop_hit_q;
      pop_msg_d    = pop_msg_q;
      inv_en       = 1'b0;
      unique case (q_state_q)
         QIdle: begin
            if (grant_valid) begin
               granted_d    = grant_idx;
               chip_d       = req_id[grant_idx];
               search_idx_d = '0;
               best_found_d = 1'b0;
               q_state_d    = QSearch;
            end
         end
         QSearch: begin
            if (take) begin
               best_found_d = 1'b1;
               best_idx_d   = search_idx_q;
               best_seq_d   = rd_seq;
               best_msg_d   = rd_msg;
            end
            if (search_idx_q == idx_t'(DEPTH - 1)) begin
               pop_ack_d = NUM_CHAINS'(1) << granted_q;
               pop_hit_d = best_found_d;
               if (best_found_d) pop_msg_d = best_msg_d;
               q_state_d = QResp;
            end else begin
               search_idx_d = search_idx_q + 1'b1;
            end
         end
         QResp: begin
            inv_en    = best_found_q;
            rr_d      = granted_q;
            q_state_d = QIdle;
         end
         default: q_state_d = QIdle;
      endcase
   end

   // Pop state and registered response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_state_q    <= QIdle;
         granted_q    <= '0;
         chip_q       <= '0;
         search_idx_q <= '0;
         best_found_q <= 1'b0;
         best_idx_q   <= '0;
         best_seq_q   <= '0;
         best_msg_q   <= '0;
         rr_q         <= chain_t'(NUM_CHAINS - 1);
         pop_ack_q    <= '0;
         pop_hit_q    <= 1'b0;
         pop_msg_q    <= '0;
      end else begin
         q_state_q    <= q_state_d;
         granted_q    <= granted_d;
         chip_q       <= chip_d;
         search_idx_q <= search_idx_d;
         best_found_q <= best_found_d;
         best_idx_q   <= best_idx_d;
         best_seq_q   <= best_seq_d;
         best_msg_q   <= best_msg_d;
         rr_q         <= rr_d;
         pop_ack_q    <= pop_ack_d;
         pop_hit_q    <= pop_hit_d;
         pop_msg_q    <= pop_msg_d;
      end
   end

   assign bus.pop_ack     = pop_ack_q;
   assign bus.pop_hit     = pop_hit_q;
   assign bus.pop_message = pop_msg_q;
   assign bus.full        = full;
   assign bus.occupancy   = occupancy;

endmodule

// File: tb/tb_mrr_loopback_queue_rr.sv
// Scoreboard bench for mrr_loopback_queue_rr; SEQ_LEN is reduced so the counter wrap is reachable.
module tb_mrr_loopback_queue_rr;

   localparam int unsigned NC    = 4;
   localparam int unsigned CL    = 8;
   localparam int unsigned ML    = 32;
   localparam int unsigned DL    = 4;
   localparam int unsigned SL    = 5;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned POP_LAT = DEPTH + 2;  // negedges from request drive to ack

   typedef struct packed {
      logic [NC-1:0] ack;
      logic          hit;
      logic [ML-1:0] msg;
   } resp_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    checks = 0;
   int    failures = 0;
   resp_t exp_q[$];

   always #5 clk = ~clk;

   mrr_loopback_queue_rr_if #(
      .NUM_CHAINS (NC),
      .CHIP_ID_LEN(CL),
      .MSG_LEN    (ML),
      .DEPTH_LOG2 (DL)
   ) bus ();

   mrr_loopback_queue_rr #(
      .NUM_CHAINS (NC),
      .CHIP_ID_LEN(CL),
      .MSG_LEN    (ML),
      .DEPTH_LOG2 (DL),
      .SEQ_LEN    (SL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_pop(input int ch, input logic hit, input logic [ML-1:0] msg);
      resp_t e;
      e.ack = NC'(1) << ch;
      e.hit = hit;
      e.msg = msg;
      exp_q.push_back(e);
   endtask

   // Monitor: every ack is matched against the oldest expected response.
   always @(negedge clk) begin
      resp_t e;
      if (!rst && bus.pop_ack != '0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop_ack", 64'(bus.pop_ack), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("pop_ack", 64'(bus.pop_ack), 64'(e.ack));
            check("pop_hit", 64'(bus.pop_hit), 64'(e.hit));
            check("pop_message", 64'(bus.pop_message), 64'(e.msg));
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      bus.pop_request  = '0;
      bus.push_request = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic do_push(input logic [CL-1:0] id, input logic [ML-1:0] msg);
      int lat;
      @(posedge clk); #1;
      bus.push_chip_id = id;
      bus.push_message = msg;
      bus.push_request = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.push_ack && lat < 100);
      check("push_latency", 64'(lat), 64'd2);
      @(posedge clk); #1;
      bus.push_request = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_pop(input int ch, input logic [CL-1:0] id);
      int lat;
      @(posedge clk); #1;
      bus.pop_chip_id[ch*CL +: CL] = id;
      bus.pop_request[ch] = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.pop_ack[ch] && lat < 100);
      check("pop_latency", 64'(lat), 64'(POP_LAT));
      @(posedge clk); #1;
      bus.pop_request[ch] = 1'b0;
   endtask

   initial begin
      int w;
      bus.pop_chip_id  = '0;
      bus.pop_request  = '0;
      bus.push_chip_id = '0;
      bus.push_message = '0;
      bus.push_request = 1'b0;

      // Reset state
      do_reset();
      check("rst_pop_ack", 64'(bus.pop_ack), 64'd0);
      check("rst_pop_hit", 64'(bus.pop_hit), 64'd0);
      check("rst_pop_message", 64'(bus.pop_message), 64'd0);
      check("rst_push_ack", 64'(bus.push_ack), 64'd0);
      check("rst_full", 64'(bus.full), 64'd0);
      check("rst_occupancy", 64'(bus.occupancy), 64'd0);

      // Two messages for the same chip come back oldest first, then a miss
      do_push(8'd5, 32'h11);
      do_push(8'd5, 32'h22);
      check("occ_two", 64'(bus.occupancy), 64'd2);
      expect_pop(0, 1'b1, 32'h11);
      do_pop(0, 8'd5);
      check("occ_one", 64'(bus.occupancy), 64'd1);
      expect_pop(0, 1'b1, 32'h22);
      do_pop(0, 8'd5);
      check("occ_zero", 64'(bus.occupancy), 64'd0);
      expect_pop(0, 1'b0, 32'h22);
      do_pop(0, 8'd5);
      check("occ_after_miss", 64'(bus.occupancy), 64'd0);

      // Fill, stall a push while full, release it with a pop hit
      do_reset();
      for (int i = 0; i < 16; i++) do_push(8'd7, 32'h100 + 32'(i));
      check("full_set", 64'(bus.full), 64'd1);
      check("occ_full", 64'(bus.occupancy), 64'd16);
      @(posedge clk); #1;
      bus.push_chip_id = 8'd9;
      bus.push_message = 32'hABCD;
      bus.push_request = 1'b1;
      repeat (4) @(negedge clk);
      check("stall_no_ack", 64'(bus.push_ack), 64'd0);
      expect_pop(1, 1'b1, 32'h100);
      do_pop(1, 8'd7);
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!bus.push_ack && w < 100);
      check("stalled_push_latency", 64'(w), 64'd2);
      @(posedge clk); #1;
      bus.push_request = 1'b0;
      @(posedge clk); #1;
      check("refill_full", 64'(bus.full), 64'd1);
      check("refill_occ", 64'(bus.occupancy), 64'd16);
      expect_pop(2, 1'b1, 32'hABCD);
      do_pop(2, 8'd9);
      check("occ_after_drain_one", 64'(bus.occupancy), 64'd15);

      // All chains request the same chip ID continuously: RR order, oldest first
      do_reset();
      for (int i = 0; i < 4; i++) do_push(8'd3, 32'h31 + 32'(i));
      for (int n = 0; n < 4; n++) expect_pop(n, 1'b1, 32'h31 + 32'(n));
      @(posedge clk); #1;
      bus.pop_chip_id = {8'd3, 8'd3, 8'd3, 8'd3};
      bus.pop_request = 4'b1111;
      for (int n = 0; n < 4; n++) begin
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (bus.pop_ack == '0 && w < 100);
         check("rr_spacing", 64'(w), 64'(DEPTH + 2));
         @(posedge clk); #1;
         bus.pop_request[n] = 1'b0;
      end
      check("rr_occ", 64'(bus.occupancy), 64'd0);

      // Sequence wrap: X at seq 31 must beat Y at seq 0 even though Y sits in a lower slot
      do_reset();
      for (int i = 0; i < 30; i++) begin
         do_push(8'h20, 32'(i));
         expect_pop(0, 1'b1, 32'(i));
         do_pop(0, 8'h20);
      end
      do_push(8'h21, 32'hF0);     // seq 30, slot 0
      do_push(8'd6, 32'hAAAA);    // seq 31, slot 1
      expect_pop(0, 1'b1, 32'hF0);
      do_pop(0, 8'h21);
      do_push(8'd6, 32'hBBBB);    // seq 0, slot 0
      expect_pop(0, 1'b1, 32'hAAAA);
      do_pop(0, 8'd6);
      expect_pop(0, 1'b1, 32'hBBBB);
      do_pop(0, 8'd6);

      // Push write lands on the same edge as a pop invalidate
      do_reset();
      do_push(8'd8, 32'h81);
      expect_pop(2, 1'b1, 32'h81);
      @(posedge clk); #1;
      bus.pop_chip_id[2*CL +: CL] = 8'd8;
      bus.pop_request[2] = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!bus.pop_ack[2] && w < 100);
      check("overlap_pop_latency", 64'(w), 64'(POP_LAT));
      bus.push_chip_id = 8'd8;
      bus.push_message = 32'h82;
      bus.push_request = 1'b1;
      @(posedge clk); #1;
      bus.pop_request[2] = 1'b0;
      check("overlap_occ", 64'(bus.occupancy), 64'd1);
      @(negedge clk);
      check("overlap_push_ack", 64'(bus.push_ack), 64'd1);
      @(posedge clk); #1;
      bus.push_request = 1'b0;
      @(posedge clk); #1;
      expect_pop(2, 1'b1, 32'h82);
      do_pop(2, 8'd8);
      expect_pop(2, 1'b0, 32'h82);
      do_pop(2, 8'd8);

      // Reset in the middle of a search aborts it with no ack
      do_reset();
      do_push(8'd4, 32'h44);
      @(posedge clk); #1;
      bus.pop_chip_id[3*CL +: CL] = 8'd4;
      bus.pop_request[3] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.pop_request = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_pop_ack", 64'(bus.pop_ack), 64'd0);
      check("abort_occ", 64'(bus.occupancy), 64'd0);
      repeat (DEPTH + 4) @(posedge clk);
      @(negedge clk);
      check("abort_late_ack", 64'(bus.pop_ack), 64'd0);
      expect_pop(3, 1'b0, 32'h0);
      do_pop(3, 8'd4);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
